booth_accumulator: RTL and testbench

BOOTH_ACCUMULATOR -- requirements
Module: booth_accumulator

---
 rtl/booth_accumulator.sv | 155 +++++++++++++++
 tb/tb_booth_accumulator.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/booth_accumulator.sv
// Accumulates a programmable number of signed 16-bit products from an upstream
// modified-Booth multiplier into a saturating signed accumulator. The result is
// held with a valid/ready handshake. Products that arrive while a result waits
// to be accepted are discarded and flagged with a one-cycle drop pulse.
module booth_accumulator #(
  parameter int unsigned ACC_W = 24,  // legal range 17..32
  parameter int unsigned LEN_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic [LEN_W-1:0] len,
  input  logic [15:0]      prod,
  input  logic             done,
  output logic [ACC_W-1:0] acc_out,
  output logic             acc_valid,
  input  logic             acc_ready,
  output logic             busy,
  output logic             ovf,
  output logic             drop
);

  typedef enum logic [1:0] {
    StIdle,
    StAccum,
    StHold
  } state_e;

  // Saturation limits of the signed accumulator.
  localparam logic [ACC_W-1:0] AccMax = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic [ACC_W-1:0] AccMin = {1'b1, {(ACC_W-1){1'b0}}};

  state_e             state_q, state_d;
  logic [ACC_W-1:0]   acc_q, acc_d;
  logic [LEN_W-1:0]   cnt_q, cnt_d;
  logic [LEN_W-1:0]   len_q, len_d;
  logic               ovf_q, ovf_d;
  logic               drop_q, drop_d;

  logic [ACC_W-1:0]   prod_ext;
  logic [ACC_W:0]     sum_wide;
  logic               sum_ovf;
  logic [ACC_W-1:0]   sum_sat;
  logic [LEN_W-1:0]   len_eff;
  logic [LEN_W-1:0]   cnt_inc;
  logic               start;

  // Datapath: sign-extend the product, add one bit wider than the accumulator
  // and clamp when the two top bits of the wide sum disagree.
  always_comb begin
    prod_ext = {{(ACC_W-16){prod[15]}}, prod};
    sum_wide = {acc_q[ACC_W-1], acc_q} + {prod_ext[ACC_W-1], prod_ext};
    sum_ovf  = sum_wide[ACC_W] ^ sum_wide[ACC_W-1];
    if (!sum_ovf) begin
      sum_sat = sum_wide[ACC_W-1:0];
    end else if (sum_wide[ACC_W]) begin
      sum_sat = AccMin;
    end else begin
      sum_sat = AccMax;
    end
    // A term count of zero behaves as a single-product result.
    len_eff = (len == '0) ? LEN_W'(1) : len;
    cnt_inc = cnt_q + LEN_W'(1);
  end

  // Next-state logic: FSM transitions, accumulator update, drop and clear.
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    len_d   = len_q;
    ovf_d   = ovf_q;
    drop_d  = 1'b0;
    start   = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (done) begin
          start = 1'b1;
        end
      end
      StAccum: begin
        if (done) begin
          acc_d = sum_sat;
          cnt_d = cnt_inc;
          ovf_d = ovf_q | sum_ovf;
          if (cnt_inc == len_q) begin
            state_d = StHold;
          end
        end
      end
      StHold: begin
        if (acc_ready) begin
          // Retiring and starting in the same edge keeps back-to-back results
          // free of a bubble.
          if (done) begin
            start = 1'b1;
          end else begin
            state_d = StIdle;
          end
        end else if (done) begin
          drop_d = 1'b1;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    // First product of a result: load rather than add, and latch the length.
    if (start) begin
      acc_d   = prod_ext;
      cnt_d   = LEN_W'(1);
      ovf_d   = 1'b0;
      len_d   = len_eff;
      state_d = (len_eff == LEN_W'(1)) ? StHold : StAccum;
    end

    // Clear wins over any handshake or product in the same cycle.
    if (clear) begin
      state_d = StIdle;
      acc_d   = '0;
      cnt_d   = '0;
      ovf_d   = 1'b0;
      drop_d  = 1'b0;
    end
  end

  // State registers with asynchronous active-high reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      acc_q   <= '0;
      cnt_q   <= '0;
      len_q   <= '0;
      ovf_q   <= 1'b0;
      drop_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      len_q   <= len_d;
      ovf_q   <= ovf_d;
      drop_q  <= drop_d;
    end
  end

  // All outputs come straight from registers.
  assign acc_out   = acc_q;
  assign acc_valid = (state_q == StHold);
  assign busy      = (state_q != StIdle);
  assign ovf       = ovf_q;
  assign drop      = drop_q;

endmodule

// File: tb/tb_booth_accumulator.sv
// Bench for booth_accumulator: two instances (ACC_W=24 and ACC_W=18) share one
// stimulus stream so each vector checks both the wide and the saturating case.
module tb_booth_accumulator;

  logic        clk = 1'b0;
  logic        rst, clear, done, acc_ready;
  logic [3:0]  len;
  logic [15:0] prod;

  logic [23:0] acc24;
  logic        v24, b24, o24, d24;
  logic [17:0] acc18;
  logic        v18, b18, o18, d18;

  always #5 clk = ~clk;

  booth_accumulator #(.ACC_W(24), .LEN_W(4)) u_dut24 (
    .clk(clk), .rst(rst), .clear(clear), .len(len), .prod(prod), .done(done),
    .acc_out(acc24), .acc_valid(v24), .acc_ready(acc_ready), .busy(b24),
    .ovf(o24), .drop(d24)
  );

  booth_accumulator #(.ACC_W(18), .LEN_W(4)) u_dut18 (
    .clk(clk), .rst(rst), .clear(clear), .len(len), .prod(prod), .done(done),
    .acc_out(acc18), .acc_valid(v18), .acc_ready(acc_ready), .busy(b18),
    .ovf(o18), .drop(d18)
  );

  int n_chk  = 0;
  int n_fail = 0;

  typedef struct packed {
    int e24;
    bit o24;
    int e18;
    bit o18;
  } exp_t;

  typedef struct packed {
    logic [3:0]        len;
    logic [4:0]        n;
    bit                rdy;
    logic [14:0][15:0] p;
    int                e24;
    bit                o24;
    int                e18;
    bit                o18;
  } vec_t;

  localparam int NV = 8;
  vec_t vecs[NV];
  exp_t sb[$];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic signed [63:0] act,
                     input logic signed [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Fill a vector whose products are pa repeated na times then pb.
  task automatic fill(input int i, input int ln, input int n, input bit rdy,
                      input int pa, input int na, input int pb,
                      input int e24, input bit eo24, input int e18, input bit eo18);
    vecs[i]     = '0;
    vecs[i].len = 4'(ln);
    vecs[i].n   = 5'(n);
    vecs[i].rdy = rdy;
    for (int k = 0; k < 15; k++) vecs[i].p[k] = (k < na) ? 16'(pa) : 16'(pb);
    vecs[i].e24 = e24;
    vecs[i].o24 = eo24;
    vecs[i].e18 = e18;
    vecs[i].o18 = eo18;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    exp_t e;
    rst = 1'b1; clear = 1'b0; done = 1'b0; acc_ready = 1'b0; len = '0; prod = '0;

    //        i len  n rdy    pa  na     pb      e24 o      e18 o
    fill(0,   3,  3, 1'b1,     0,  0,     0,      37, 0,      37, 0);
    fill(1,   1,  1, 1'b0,   -20,  1,     0,     -20, 0,     -20, 0);
    fill(2,   0,  1, 1'b1,   100,  1,     0,     100, 0,     100, 0);
    fill(3,   2,  2, 1'b0, 32767,  2,     0,   65534, 0,   65534, 0);
    fill(4,  15, 15, 1'b0, 16384, 15,     0,  245760, 0,  131071, 1);
    fill(5,  15, 15, 1'b1, -32768, 15,    0, -491520, 0, -131072, 1);
    fill(6,  10, 10, 1'b0, 16384,  8, -16384,  98304, 0,   98303, 1);
    fill(7,   5,  5, 1'b0,     0,  0,     0,   -1998, 0,   -1998, 0);
    vecs[0].p[0] = 16'(21);   vecs[0].p[1] = 16'(-20);  vecs[0].p[2] = 16'(36);
    vecs[7].p[0] = 16'(1000); vecs[7].p[1] = 16'(-3000); vecs[7].p[2] = 16'(7);
    vecs[7].p[3] = 16'(0);    vecs[7].p[4] = 16'(-5);

    // Reset state, observed before any clock edge.
    #2;
    chk("rst_acc", $signed(acc24), 0);
    chk("rst_valid", v24, 0);
    chk("rst_busy", b24, 0);
    chk("rst_ovf", o24, 0);
    chk("rst_drop", d24, 0);
    step();
    step();
    rst = 1'b0;
    step();

    // Table-driven results through the scoreboard.
    for (int v = 0; v < NV; v++) begin
      acc_ready = vecs[v].rdy;
      len       = vecs[v].len;
      for (int k = 0; k < int'(vecs[v].n); k++) begin
        done = 1'b1;
        prod = vecs[v].p[k];
        if (k == int'(vecs[v].n) - 1) begin
          sb.push_back('{vecs[v].e24, vecs[v].o24, vecs[v].e18, vecs[v].o18});
        end
        step();
        done = 1'b0;
        if (k != int'(vecs[v].n) - 1) begin
          if (v % 2 == 1) step();  // idle cycle inside the accumulation
          chk($sformatf("v%0d_mid_valid", v), v24, 0);
          chk($sformatf("v%0d_mid_busy", v), b24, 1);
        end
      end
      chk($sformatf("v%0d_valid", v), v24, 1);
      chk($sformatf("v%0d_valid18", v), v18, 1);
      if (sb.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL v%0d_sb: got empty queue expected entry", v);
      end else begin
        e = sb.pop_front();
        chk($sformatf("v%0d_acc24", v), $signed(acc24), e.e24);
        chk($sformatf("v%0d_ovf24", v), o24, e.o24);
        chk($sformatf("v%0d_acc18", v), $signed(acc18), e.e18);
        chk($sformatf("v%0d_ovf18", v), o18, e.o18);
        if (v == 1) chk("v1_raw_hex", acc24, 24'hFFFFEC);
        if (!vecs[v].rdy) begin
          step();
          chk($sformatf("v%0d_hold_valid", v), v24, 1);
          chk($sformatf("v%0d_hold_acc", v), $signed(acc24), e.e24);
          chk($sformatf("v%0d_hold_ovf18", v), o18, e.o18);
          acc_ready = 1'b1;
        end
      end
      step();
      chk($sformatf("v%0d_retire_valid", v), v24, 0);
      chk($sformatf("v%0d_retire_busy", v), b24, 0);
      acc_ready = 1'b0;
    end

    // Held result with a stray product: dropped, result untouched.
    len = 4'd2; done = 1'b1; prod = 16'd3; step();
    prod = 16'd4; step();
    prod = 16'd5; step();
    chk("drop_pulse", d24, 1);
    chk("drop_acc", $signed(acc24), 7);
    chk("drop_valid", v24, 1);
    done = 1'b0; step();
    chk("drop_end", d24, 0);
    chk("drop_acc2", $signed(acc24), 7);
    acc_ready = 1'b1; step();
    chk("drop_idle", b24, 0);
    acc_ready = 1'b0;

    // Retire and restart in the same edge.
    len = 4'd1; done = 1'b1; prod = 16'd9; step();
    chk("b2b_first", $signed(acc24), 9);
    acc_ready = 1'b1; len = 4'd2; prod = 16'd7; step();
    chk("b2b_valid", v24, 0);
    chk("b2b_busy", b24, 1);
    chk("b2b_acc", $signed(acc24), 7);
    acc_ready = 1'b0; prod = 16'd1; step();
    chk("b2b_done", v24, 1);
    chk("b2b_sum", $signed(acc24), 8);
    done = 1'b0; acc_ready = 1'b1; step();
    acc_ready = 1'b0;

    // Saturate the narrow instance, change len mid-way, then reset asynchronously.
    len = 4'd15; done = 1'b1; prod = 16'd16384; step();
    len = 4'd1;
    for (int k = 1; k < 9; k++) step();
    done = 1'b0;
    chk("len_ignored", v24, 0);
    chk("mid_acc24", $signed(acc24), 147456);
    chk("mid_ovf18", o18, 1);
    chk("mid_acc18", $signed(acc18), 131071);
    #3 rst = 1'b1;
    #1;
    chk("arst_acc", $signed(acc24), 0);
    chk("arst_busy", b24, 0);
    chk("arst_valid", v24, 0);
    chk("arst_ovf18", o18, 0);
    chk("arst_acc18", $signed(acc18), 0);
    chk("arst_drop", d24, 0);
    rst = 1'b0;
    @(posedge clk); #1;

    // First product after reset starts fresh; clear aborts.
    len = 4'd3; done = 1'b1; prod = 16'd1; step();
    chk("post_rst_acc", $signed(acc24), 1);
    prod = 16'd2; step();
    chk("post_rst_acc2", $signed(acc24), 3);
    clear = 1'b1; prod = 16'd100; acc_ready = 1'b1; step();
    chk("clr_busy", b24, 0);
    chk("clr_acc", $signed(acc24), 0);
    chk("clr_valid", v24, 0);
    clear = 1'b0; acc_ready = 1'b0; len = 4'd2; prod = 16'd5; step();
    prod = 16'd6; step();
    done = 1'b0;
    chk("clr_next_valid", v24, 1);
    chk("clr_next_acc", $signed(acc24), 11);
    acc_ready = 1'b1; step();
    chk("clr_next_idle", b24, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
